// File: rtl/cv32e40x_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_div_iter
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU. It runs one
//               shift/subtract step per cycle and can skip the leading zero
//               bits of the dividend magnitude. Divide-by-zero and signed
//               overflow return their fixed results without iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40x_div_iter #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             signed_i,
    input  logic             rem_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int               c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_valid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_signed;
    logic               r_rem_sel;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_prem;
    logic [WIDTH-1:0]   r_q;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div0;
    logic               w_ovf;
    logic [c_cnt_w-1:0] w_n;
    logic [c_cnt_w-1:0] w_shift;
    logic [WIDTH-1:0]   w_q_init;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_prem_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand magnitudes and special-case detection from the latched request
    assign w_sign_a = r_signed & r_opa[WIDTH-1];
    assign w_sign_b = r_signed & r_opb[WIDTH-1];
    assign w_mag_a  = w_sign_a ? (~r_opa + 1'b1) : r_opa;
    assign w_mag_b  = w_sign_b ? (~r_opb + 1'b1) : r_opb;
    assign w_div0   = (r_opb == '0);
    assign w_ovf    = r_signed && (r_opa == c_most_neg) && (r_opb == '1);

    // Iteration count: significant bits of |a| (at least one), or full width
    always_comb begin
        w_n = c_cnt_w'(1);
        for (int i = 0; i < WIDTH; i++) begin
            if (w_mag_a[i]) begin
                w_n = c_cnt_w'(i + 1);
            end
        end
        if (!EARLY_TERM) begin
            w_n = c_cnt_w'(WIDTH);
        end
        w_shift  = c_cnt_w'(WIDTH) - w_n;
        w_q_init = w_mag_a << w_shift;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The partial remainder stays below the divisor, so the shifted value fits
    // in WIDTH+1 bits and the top bit of the difference is a valid borrow.
    assign w_rem_sh  = {r_prem, r_q[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_prem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_q_nx    = {r_q[WIDTH-2:0], w_ge};
    assign w_quo_fix = r_sign_q ? (~w_q_nx + 1'b1) : w_q_nx;
    assign w_rem_fix = r_sign_r ? (~w_prem_nx + 1'b1) : w_prem_nx;

    // Control FSM with datapath registers; kill aborts from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_signed  <= 1'b0;
            r_rem_sel <= 1'b0;
            r_b       <= '0;
            r_prem    <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
        end else if (kill_i) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_opa     <= opa_i;
                        r_opb     <= opb_i;
                        r_signed  <= signed_i;
                        r_rem_sel <= rem_i;
                        r_state   <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (w_div0) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= r_rem_sel ? r_opa : '1;
                    end else if (w_ovf) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= r_rem_sel ? '0 : c_most_neg;
                    end else begin
                        r_b      <= w_mag_b;
                        r_prem   <= '0;
                        r_q      <= w_q_init;
                        r_cnt    <= w_n;
                        r_sign_q <= w_sign_a ^ w_sign_b;
                        r_sign_r <= w_sign_a;
                        r_state  <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_prem <= w_prem_nx;
                    r_q    <= w_q_nx;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= r_rem_sel ? w_rem_fix : w_quo_fix;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_state  <= S_IDLE;
                        r_valid  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_valid  <= 1'b0;
                    r_result <= '0;
                end
            endcase
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign busy_o   = (r_state != S_IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40x_div_iter
// Description : Self-checking bench for cv32e40x_div_iter (WIDTH=32,
//               EARLY_TERM=1) against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40x_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        signed_i;
    logic        rem_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    cv32e40x_div_iter #(.WIDTH(32), .EARLY_TERM(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .signed_i (signed_i),
        .rem_i    (rem_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result from the RISC-V division rules
    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn, input bit rem);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
        return rem ? (a % b) : (a / b);
    endfunction

    // Reference cycle of first valid_o, counting the accept cycle as 0
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] m;
        int n;
        if (b == 32'd0) return 2;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        m = (sgn && a[31]) ? (32'd0 - a) : a;
        n = 0;
        while (m != 32'd0) begin
            n++;
            m = m >> 1;
        end
        if (n == 0) n = 1;
        return n + 2;
    endfunction

    // Issue one operation, check latency, result and hold behaviour, then release it
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         input bit rem, input int hold, input bit spam, input string tag);
        int          w;
        int          cyc;
        bit          zero_ok;
        bit          stable;
        logic [31:0] got;
        w = 0;
        while (!ready_o && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_ready"}, 64'(ready_o), 64'd1);
        opa_i    = a;
        opb_i    = b;
        signed_i = sgn;
        rem_i    = rem;
        valid_i  = 1'b1;
        ready_i  = 1'b0;
        tick();
        if (spam) begin
            opa_i    = $urandom;
            opb_i    = $urandom;
            signed_i = ~sgn;
            rem_i    = ~rem;
        end else begin
            valid_i = 1'b0;
        end
        cyc     = 1;
        zero_ok = 1'b1;
        while (!valid_o && cyc < 80) begin
            if (result_o !== 32'd0) zero_ok = 1'b0;
            tick();
            cyc++;
        end
        valid_i = 1'b0;
        check({tag, "_lat"}, 64'(cyc), 64'(ref_lat(a, b, sgn)));
        check({tag, "_res"}, 64'(result_o), 64'(ref_res(a, b, sgn, rem)));
        check({tag, "_zero"}, 64'(zero_ok), 64'd1);
        got    = result_o;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (valid_o !== 1'b1 || result_o !== got) stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold"}, 64'(stable), 64'd1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check({tag, "_idle"}, {61'd0, ready_o, valid_o, (result_o == 32'd0)}, 64'b101);
    endtask

    initial begin : main
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        bit          seen;

        rst      = 1'b1;
        valid_i  = 1'b0;
        signed_i = 1'b0;
        rem_i    = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        kill_i   = 1'b0;
        ready_i  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset", {60'd0, ready_o, busy_o, valid_o, (result_o == 32'd0)}, 64'b1001);

        // Directed arithmetic and special cases
        do_op(32'd100, 32'd7, 1'b0, 1'b0, 0, 1'b0, "divu_100_7");
        do_op(32'd100, 32'd7, 1'b0, 1'b1, 0, 1'b0, "remu_100_7");
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, 1'b0, "div_m7_2");
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, 1'b0, "rem_m7_2");
        do_op(32'd5, 32'd0, 1'b0, 1'b0, 0, 1'b0, "divu_5_0");
        do_op(32'd5, 32'd0, 1'b0, 1'b1, 0, 1'b0, "remu_5_0");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0, "div_ovf");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 1'b0, "rem_ovf");
        do_op(32'd0, 32'd3, 1'b1, 1'b0, 0, 1'b0, "div_zero_a");

        // Result held while the consumer stalls; requests while busy are ignored
        do_op(32'd100, 32'd7, 1'b0, 1'b0, 3, 1'b0, "hold3");
        do_op(32'hDEAD_BEEF, 32'd1234, 1'b1, 1'b1, 1, 1'b1, "busy_spam");

        // Kill in ITER cycle 4
        opa_i = 32'd100; opb_i = 32'd7; signed_i = 1'b0; rem_i = 1'b0; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick(); tick(); tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check("kill_iter", {61'd0, ready_o, valid_o, busy_o}, 64'b100);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (valid_o) seen = 1'b1;
            tick();
        end
        check("kill_no_valid", 64'(seen), 64'd0);

        // Kill wins over a simultaneous accept
        valid_i = 1'b1; kill_i = 1'b1;
        tick();
        valid_i = 1'b0; kill_i = 1'b0;
        check("kill_accept", {62'd0, ready_o, busy_o}, 64'b10);

        // Kill wins over ready_i in DONE
        opa_i = 32'd5; opb_i = 32'd0; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        check("done_reached", 64'(valid_o), 64'd1);
        kill_i = 1'b1; ready_i = 1'b1;
        tick();
        kill_i = 1'b0; ready_i = 1'b0;
        check("kill_done", {61'd0, ready_o, valid_o, (result_o == 32'd0)}, 64'b101);

        // Reset in ITER cycle 3, then a fresh operation
        opa_i = 32'd100; opb_i = 32'd7; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        rst = 1'b1; kill_i = 1'b1; ready_i = 1'b1;
        tick();
        rst = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
        check("rst_iter", {60'd0, ready_o, busy_o, valid_o, (result_o == 32'd0)}, 64'b1001);
        do_op(32'd9, 32'd3, 1'b0, 1'b0, 0, 1'b0, "divu_9_3");

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 7));
            ra  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) ra = $urandom;
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3, 4:    rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
